// File: rtl/vault_pkg.sv
// Shared op/status codes, controller state encoding and flash record layout for pass_vault_ctrl.
package vault_pkg;

    typedef enum logic [1:0] {
        OP_FETCH = 2'b00,
        OP_STORE = 2'b01,
        OP_ERASE = 2'b10,
        OP_BAD   = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_OK      = 2'b00,
        ST_MISS    = 2'b01,
        ST_FULL    = 2'b10,
        ST_ILLEGAL = 2'b11
    } status_e;

    typedef enum logic [3:0] {
        BOOT_RD, BOOT_LD, IDLE, SEARCH, FL_RD, FL_WAIT, CIPH_START, CIPH_WAIT, WRITE, DONE
    } state_e;

    // A flash record is two DATA_W words: account tag in the high word, ciphertext in the low word.
    localparam int ACC_HI = 1;
    localparam int ACC_LO = 0;

endpackage

// File: rtl/vault_cam.sv
// Account-tag CAM: ENTRIES tags with valid bits, one write port, lowest-index hit and free encoders.
module vault_cam
    import vault_pkg::*;
#(
    parameter int DATA_W  = 128,
    parameter int ENTRIES = 16,
    parameter int ADDR_W  = $clog2(ENTRIES)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_idx,
    input  logic [DATA_W-1:0] wr_tag,
    input  logic              wr_valid,
    input  logic [DATA_W-1:0] key,
    output logic              hit,
    output logic [ADDR_W-1:0] hit_idx,
    output logic              free,
    output logic [ADDR_W-1:0] free_idx
);

    logic [DATA_W-1:0]  tags [ENTRIES];
    logic [ENTRIES-1:0] valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= '0;
        end else if (wr_en) begin
            valid[wr_idx] <= wr_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            tags[wr_idx] <= wr_tag;
        end
    end

    // Scanning top-down lets the lowest matching / lowest free index win.
    always_comb begin
        hit      = 1'b0;
        hit_idx  = '0;
        free     = 1'b0;
        free_idx = '0;
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (valid[i] && (tags[i] == key)) begin
                hit     = 1'b1;
                hit_idx = ADDR_W'(i);
            end
            if (!valid[i]) begin
                free     = 1'b1;
                free_idx = ADDR_W'(i);
            end
        end
    end

endmodule

// File: rtl/pass_vault_ctrl.sv
// Password-vault controller: boots CAM from flash, then serves FETCH/STORE (and ERASE when
// VAULT_ERASE_EN is defined) through the external cipher core and flash record port.
//
// state      | meaning
// BOOT_RD    | flash_addr = boot_idx presented
// BOOT_LD    | flash_rdata account loaded into CAM slot boot_idx
// IDLE       | waiting for go
// SEARCH     | CAM lookup on latched account
// FL_RD      | flash_addr = hit slot presented
// FL_WAIT    | ciphertext valid on flash_rdata
// CIPH_START | ciph_start pulse
// CIPH_WAIT  | waiting for ciph_done
// WRITE      | flash_we pulse, CAM slot updated
// DONE       | done pulse, status valid
module pass_vault_ctrl
    import vault_pkg::*;
#(
    parameter int DATA_W  = 128,
    parameter int ENTRIES = 16,
    parameter int ADDR_W  = $clog2(ENTRIES)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                go,
    input  logic [1:0]          op,
    input  logic [DATA_W-1:0]   account,
    input  logic [DATA_W-1:0]   password,
    input  logic [ADDR_W:0]     boot_count,
    output logic                busy,
    output logic                done,
    output logic [1:0]          status,
    output logic [DATA_W-1:0]   password_out,
    output logic [ADDR_W-1:0]   flash_addr,
    input  logic [2*DATA_W-1:0] flash_rdata,
    output logic [2*DATA_W-1:0] flash_wdata,
    output logic                flash_we,
    output logic                ciph_start,
    output logic                ciph_decrypt,
    output logic [DATA_W-1:0]   ciph_din,
    input  logic [DATA_W-1:0]   ciph_dout,
    input  logic                ciph_done
);

    localparam logic [ADDR_W:0] MAX_N = (ADDR_W + 1)'(ENTRIES);

    state_e              state;
    logic [ADDR_W-1:0]   boot_idx;
    logic [ADDR_W-1:0]   slot_q;
    logic [1:0]          op_q;
    logic [DATA_W-1:0]   account_q;
    logic [DATA_W-1:0]   password_q;

    logic [ADDR_W:0]     boot_n;
    logic                boot_last;
    logic                cam_we;
    logic [ADDR_W-1:0]   cam_idx;
    logic [DATA_W-1:0]   cam_tag;
    logic                cam_valid;
    logic                hit;
    logic [ADDR_W-1:0]   hit_idx;
    logic                free;
    logic [ADDR_W-1:0]   free_idx;

    assign boot_n    = (boot_count > MAX_N) ? MAX_N : boot_count;
    assign boot_last = ({1'b0, boot_idx} == (boot_n - 1'b1));

    // Boot loads come straight from flash; command writes use the latched account.
    always_comb begin
        cam_we    = 1'b0;
        cam_idx   = slot_q;
        cam_tag   = account_q;
        cam_valid = 1'b1;
        if (state == BOOT_LD) begin
            cam_we  = 1'b1;
            cam_idx = boot_idx;
            cam_tag = flash_rdata[ACC_HI*DATA_W +: DATA_W];
        end else if (state == WRITE) begin
            cam_we = 1'b1;
`ifdef VAULT_ERASE_EN
            cam_valid = (op_q != OP_ERASE);
`endif
        end
    end

    vault_cam #(
        .DATA_W  (DATA_W),
        .ENTRIES (ENTRIES),
        .ADDR_W  (ADDR_W)
    ) u_cam (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (cam_we),
        .wr_idx   (cam_idx),
        .wr_tag   (cam_tag),
        .wr_valid (cam_valid),
        .key      (account_q),
        .hit      (hit),
        .hit_idx  (hit_idx),
        .free     (free),
        .free_idx (free_idx)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= BOOT_RD;
            boot_idx     <= '0;
            slot_q       <= '0;
            op_q         <= OP_FETCH;
            account_q    <= '0;
            password_q   <= '0;
            busy         <= 1'b1;
            done         <= 1'b0;
            status       <= ST_OK;
            password_out <= '0;
            flash_addr   <= '0;
            flash_wdata  <= '0;
            flash_we     <= 1'b0;
            ciph_start   <= 1'b0;
            ciph_decrypt <= 1'b0;
            ciph_din     <= '0;
        end else begin
            done       <= 1'b0;
            flash_we   <= 1'b0;
            ciph_start <= 1'b0;
            case (state)
                BOOT_RD: begin
                    if (boot_n == '0) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        state <= BOOT_LD;
                    end
                end
                BOOT_LD: begin
                    if (boot_last) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        boot_idx   <= boot_idx + 1'b1;
                        flash_addr <= boot_idx + 1'b1;
                        state      <= BOOT_RD;
                    end
                end
                IDLE, DONE: begin
                    state <= IDLE;
                    if (go) begin
                        op_q       <= op;
                        account_q  <= account;
                        password_q <= password;
                        busy       <= 1'b1;
                        state      <= SEARCH;
                    end
                end
                SEARCH: begin
                    case (op_q)
                        OP_FETCH: begin
                            if (hit) begin
                                flash_addr <= hit_idx;
                                state      <= FL_RD;
                            end else begin
                                status <= ST_MISS;
                                done   <= 1'b1;
                                busy   <= 1'b0;
                                state  <= DONE;
                            end
                        end
                        OP_STORE: begin
                            if (hit || free) begin
                                slot_q       <= hit ? hit_idx : free_idx;
                                ciph_din     <= password_q;
                                ciph_decrypt <= 1'b0;
                                ciph_start   <= 1'b1;
                                state        <= CIPH_START;
                            end else begin
                                status <= ST_FULL;
                                done   <= 1'b1;
                                busy   <= 1'b0;
                                state  <= DONE;
                            end
                        end
`ifdef VAULT_ERASE_EN
                        OP_ERASE: begin
                            if (hit) begin
                                slot_q      <= hit_idx;
                                flash_addr  <= hit_idx;
                                flash_wdata <= '0;
                                flash_we    <= 1'b1;
                                state       <= WRITE;
                            end else begin
                                status <= ST_MISS;
                                done   <= 1'b1;
                                busy   <= 1'b0;
                                state  <= DONE;
                            end
                        end
`endif
                        default: begin
                            status <= ST_ILLEGAL;
                            done   <= 1'b1;
                            busy   <= 1'b0;
                            state  <= DONE;
                        end
                    endcase
                end
                FL_RD: state <= FL_WAIT;
                FL_WAIT: begin
                    ciph_din     <= flash_rdata[ACC_LO*DATA_W +: DATA_W];
                    ciph_decrypt <= 1'b1;
                    ciph_start   <= 1'b1;
                    state        <= CIPH_START;
                end
                CIPH_START: state <= CIPH_WAIT;
                CIPH_WAIT: begin
                    if (ciph_done) begin
                        if (op_q == OP_FETCH) begin
                            password_out <= ciph_dout;
                            status       <= ST_OK;
                            done         <= 1'b1;
                            busy         <= 1'b0;
                            state        <= DONE;
                        end else begin
                            flash_addr  <= slot_q;
                            flash_wdata <= {account_q, ciph_dout};
                            flash_we    <= 1'b1;
                            state       <= WRITE;
                        end
                    end
                end
                WRITE: begin
                    status <= ST_OK;
                    done   <= 1'b1;
                    busy   <= 1'b0;
                    state  <= DONE;
                end
                default: state <= BOOT_RD;
            endcase
        end
    end

endmodule

// File: tb/tb_pass_vault_ctrl.sv
// Directed self-checking bench for pass_vault_ctrl (ENTRIES=4) with flash and XOR-cipher models.
module tb_pass_vault_ctrl;

    localparam int DATA_W  = 128;
    localparam int ENTRIES = 4;
    localparam int ADDR_W  = 2;
    localparam logic [127:0] KEY   = {16{8'hA5}};
    localparam logic [127:0] F_LO0 = 128'h0f0e0d0c_0b0a0908_07060504_03020100;
    localparam logic [127:0] F_LO1 = 128'h11112222_33334444_55556666_77778888;
    localparam logic [127:0] F_LO2 = 128'hdeadbeef_cafef00d_01234567_89abcdef;
    localparam logic [127:0] P44   = 128'h44440000_12345678_9abcdef0_13579bdf;
    localparam logic [127:0] PN    = 128'h2222aaaa_bbbbcccc_ddddeeee_ffff0001;
    localparam logic [127:0] P66   = 128'h66666666_00000000_ffffffff_12121212;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                go = 1'b0;
    logic [1:0]          op = 2'b00;
    logic [DATA_W-1:0]   account = '0;
    logic [DATA_W-1:0]   password = '0;
    logic [ADDR_W:0]     boot_count = 3'd3;
    logic                busy;
    logic                done;
    logic [1:0]          status;
    logic [DATA_W-1:0]   password_out;
    logic [ADDR_W-1:0]   flash_addr;
    logic [2*DATA_W-1:0] flash_rdata = '0;
    logic [2*DATA_W-1:0] flash_wdata;
    logic                flash_we;
    logic                ciph_start;
    logic                ciph_decrypt;
    logic [DATA_W-1:0]   ciph_din;
    logic [DATA_W-1:0]   ciph_dout = '0;
    logic                ciph_done = 1'b0;

    int n_assert = 0;
    int n_fail   = 0;

    pass_vault_ctrl #(.DATA_W(DATA_W), .ENTRIES(ENTRIES), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst), .go(go), .op(op), .account(account), .password(password),
        .boot_count(boot_count), .busy(busy), .done(done), .status(status),
        .password_out(password_out), .flash_addr(flash_addr), .flash_rdata(flash_rdata),
        .flash_wdata(flash_wdata), .flash_we(flash_we), .ciph_start(ciph_start),
        .ciph_decrypt(ciph_decrypt), .ciph_din(ciph_din), .ciph_dout(ciph_dout),
        .ciph_done(ciph_done)
    );

    always #5 clk = ~clk;

    // Flash model: registered read, one-cycle latency; seeded on the first edge.
    logic [2*DATA_W-1:0] flash [ENTRIES];
    bit seeded = 1'b0;
    always @(posedge clk) begin
        if (!seeded) begin
            flash[0] <= {128'h11, F_LO0};
            flash[1] <= {128'h22, F_LO1};
            flash[2] <= {128'h33, F_LO2};
            flash[3] <= '0;
            seeded   <= 1'b1;
        end else if (flash_we) begin
            flash[flash_addr] <= flash_wdata;
        end
        flash_rdata <= flash[flash_addr];
    end

    // Cipher model: XOR with KEY, done pulse 5 cycles after start.
    int cnt = 0;
    always @(posedge clk) begin
        ciph_done <= 1'b0;
        if (ciph_start) begin
            cnt <= 5;
        end else if (cnt > 0) begin
            cnt <= cnt - 1;
            if (cnt == 1) begin
                ciph_done <= 1'b1;
                ciph_dout <= ciph_din ^ KEY;
            end
        end
    end

    int we_total = 0;
    always @(negedge clk) if (flash_we === 1'b1) we_total++;

    int                  r_lat, r_cdone, r_nstart, r_nwe, r_boot;
    logic                r_dec;
    logic [127:0]        r_din;
    logic [ADDR_W-1:0]   r_we_addr;
    logic [255:0]        r_we_data;

    task automatic do_reset(input logic [ADDR_W:0] bc);
        rst = 1'b1; go = 1'b0; boot_count = bc;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        r_boot = -1;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (!busy) begin r_boot = k; break; end
        end
    endtask

    task automatic run_cmd(input logic [1:0] o, input logic [127:0] acc, input logic [127:0] pw,
                           input bit glitch);
        r_lat = -1; r_cdone = -1; r_nstart = 0; r_nwe = 0;
        r_dec = 1'b0; r_din = '0; r_we_addr = '0; r_we_data = '0;
        @(negedge clk);
        go = 1'b1; op = o; account = acc; password = pw;
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            if (k == 1) go = 1'b0;
            if (glitch && k == 3) begin go = 1'b1; op = 2'b01; account = 128'h77; password = '1; end
            if (glitch && k == 4) go = 1'b0;
            if (ciph_start) begin r_nstart++; r_dec = ciph_decrypt; r_din = ciph_din; end
            if (ciph_done && r_cdone < 0) r_cdone = k;
            if (flash_we) begin r_nwe++; r_we_addr = flash_addr; r_we_data = flash_wdata; end
            if (done) begin r_lat = k; break; end
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; boot_count = 3'd3;
        repeat (3) @(negedge clk);
        n_assert++; if (busy !== 1'b1) begin n_fail++; $display("FAIL reset_busy: got %b expected 1", busy); end
        n_assert++; if ({done, flash_we, ciph_start, ciph_decrypt} !== 4'b0000) begin n_fail++; $display("FAIL reset_strobes: got %b expected 0000", {done, flash_we, ciph_start, ciph_decrypt}); end
        n_assert++; if ({status, flash_addr} !== 4'b0000 || password_out !== '0) begin n_fail++; $display("FAIL reset_regs: got status %b addr %0d pw %h expected zeros", status, flash_addr, password_out); end
        n_assert++; if (dut.u_cam.valid !== 4'b0000) begin n_fail++; $display("FAIL reset_cam: got %b expected 0000", dut.u_cam.valid); end
        do_reset(3'd3);
        n_assert++; if (r_boot !== 6) begin n_fail++; $display("FAIL boot_cycles: got %0d expected 6", r_boot); end
        n_assert++; if (dut.u_cam.valid !== 4'b0111) begin n_fail++; $display("FAIL boot_cam: got %b expected 0111", dut.u_cam.valid); end
    endtask

    task automatic test_fetch_hit;
        run_cmd(2'b00, 128'h22, '0, 1'b0);
        n_assert++; if (r_lat < 0) begin n_fail++; $display("FAIL fetch_hit_timeout: got no done expected done"); end
        n_assert++; if (flash_addr !== 2'd1) begin n_fail++; $display("FAIL fetch_hit_addr: got %0d expected 1", flash_addr); end
        n_assert++; if (r_nstart !== 1 || r_dec !== 1'b1 || r_din !== F_LO1) begin n_fail++; $display("FAIL fetch_hit_cipher: got starts %0d dec %b din %h expected 1 1 %h", r_nstart, r_dec, r_din, F_LO1); end
        n_assert++; if (status !== 2'b00) begin n_fail++; $display("FAIL fetch_hit_status: got %b expected 00", status); end
        n_assert++; if (password_out !== (F_LO1 ^ KEY)) begin n_fail++; $display("FAIL fetch_hit_pw: got %h expected %h", password_out, F_LO1 ^ KEY); end
        n_assert++; if (busy !== 1'b0) begin n_fail++; $display("FAIL fetch_hit_busy: got %b expected 0", busy); end
    endtask

    task automatic test_fetch_miss;
        run_cmd(2'b00, 128'h99, '0, 1'b0);
        n_assert++; if (r_lat !== 2) begin n_fail++; $display("FAIL fetch_miss_latency: got %0d expected 2", r_lat); end
        n_assert++; if (status !== 2'b01) begin n_fail++; $display("FAIL fetch_miss_status: got %b expected 01", status); end
        n_assert++; if (r_nstart !== 0) begin n_fail++; $display("FAIL fetch_miss_cipher: got %0d starts expected 0", r_nstart); end
        n_assert++; if (password_out !== (F_LO1 ^ KEY)) begin n_fail++; $display("FAIL fetch_miss_pw: got %h expected %h", password_out, F_LO1 ^ KEY); end
    endtask

    task automatic test_store;
        run_cmd(2'b01, 128'h44, P44, 1'b0);
        n_assert++; if (r_nwe !== 1 || r_we_addr !== 2'd3) begin n_fail++; $display("FAIL store_we: got %0d writes addr %0d expected 1 at 3", r_nwe, r_we_addr); end
        n_assert++; if (r_we_data !== {128'h44, P44 ^ KEY}) begin n_fail++; $display("FAIL store_wdata: got %h expected %h", r_we_data, {128'h44, P44 ^ KEY}); end
        n_assert++; if (r_dec !== 1'b0 || r_din !== P44) begin n_fail++; $display("FAIL store_cipher: got dec %b din %h expected 0 %h", r_dec, r_din, P44); end
        n_assert++; if (r_cdone < 0 || r_lat - r_cdone !== 2) begin n_fail++; $display("FAIL store_latency: got %0d expected 2", r_lat - r_cdone); end
        n_assert++; if (status !== 2'b00 || dut.u_cam.valid !== 4'b1111) begin n_fail++; $display("FAIL store_status: got %b cam %b expected 00 1111", status, dut.u_cam.valid); end
        run_cmd(2'b01, 128'h55, 128'h5, 1'b0);
        n_assert++; if (status !== 2'b10 || r_lat !== 2) begin n_fail++; $display("FAIL store_full: got status %b lat %0d expected 10 2", status, r_lat); end
        n_assert++; if (r_nwe !== 0 || r_nstart !== 0) begin n_fail++; $display("FAIL store_full_quiet: got %0d writes %0d starts expected 0 0", r_nwe, r_nstart); end
    endtask

    task automatic test_overwrite;
        run_cmd(2'b01, 128'h22, PN, 1'b0);
        n_assert++; if (r_nwe !== 1 || r_we_addr !== 2'd1 || r_we_data !== {128'h22, PN ^ KEY}) begin n_fail++; $display("FAIL overwrite_we: got %0d writes addr %0d data %h expected 1 at 1", r_nwe, r_we_addr, r_we_data); end
        run_cmd(2'b00, 128'h22, '0, 1'b0);
        n_assert++; if (password_out !== PN || status !== 2'b00) begin n_fail++; $display("FAIL overwrite_fetch: got %h status %b expected %h 00", password_out, status, PN); end
    endtask

    task automatic test_busy_ignore;
        int extra;
        run_cmd(2'b00, 128'h33, '0, 1'b1);
        extra = 0;
        repeat (6) begin
            @(negedge clk);
            if (done || busy) extra++;
        end
        n_assert++; if (password_out !== (F_LO2 ^ KEY) || status !== 2'b00) begin n_fail++; $display("FAIL busy_ignore_result: got %h status %b expected %h 00", password_out, status, F_LO2 ^ KEY); end
        n_assert++; if (extra !== 0) begin n_fail++; $display("FAIL busy_ignore_extra: got %0d busy/done cycles expected 0", extra); end
    endtask

    task automatic test_abort;
        bit found;
        int we_before;
        we_before = we_total;
        found = 1'b0;
        @(negedge clk);
        go = 1'b1; op = 2'b01; account = 128'h11; password = 128'hbad;
        @(negedge clk);
        go = 1'b0;
        for (int k = 0; k < 20; k++) begin
            if (ciph_start) begin found = 1'b1; break; end
            @(negedge clk);
        end
        n_assert++; if (!found) begin n_fail++; $display("FAIL abort_start: got no ciph_start expected one"); end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        n_assert++; if (flash_we !== 1'b0 || ciph_start !== 1'b0 || busy !== 1'b1 || done !== 1'b0) begin n_fail++; $display("FAIL abort_outputs: got we %b start %b busy %b done %b expected 0 0 1 0", flash_we, ciph_start, busy, done); end
        n_assert++; if (dut.u_cam.valid !== 4'b0000) begin n_fail++; $display("FAIL abort_cam: got %b expected 0000", dut.u_cam.valid); end
        do_reset(3'd3);
        n_assert++; if (r_boot !== 6 || dut.u_cam.valid !== 4'b0111) begin n_fail++; $display("FAIL abort_reboot: got %0d cycles cam %b expected 6 0111", r_boot, dut.u_cam.valid); end
        n_assert++; if (we_total !== we_before || flash[0] !== {128'h11, F_LO0}) begin n_fail++; $display("FAIL abort_flash: got %0d writes rec0 %h expected 0 writes", we_total - we_before, flash[0]); end
        run_cmd(2'b00, 128'h22, '0, 1'b0);
        n_assert++; if (password_out !== PN) begin n_fail++; $display("FAIL abort_persist: got %h expected %h", password_out, PN); end
    endtask

    task automatic test_illegal;
        run_cmd(2'b11, 128'h11, '0, 1'b0);
        n_assert++; if (status !== 2'b11 || r_lat !== 2 || r_nwe !== 0 || r_nstart !== 0) begin n_fail++; $display("FAIL illegal_op3: got status %b lat %0d we %0d st %0d expected 11 2 0 0", status, r_lat, r_nwe, r_nstart); end
`ifdef VAULT_ERASE_EN
        run_cmd(2'b10, 128'h11, '0, 1'b0);
        n_assert++; if (status !== 2'b00 || r_nwe !== 1 || r_we_addr !== 2'd0 || r_we_data !== '0) begin n_fail++; $display("FAIL erase_we: got status %b %0d writes addr %0d expected 00 1 at 0", status, r_nwe, r_we_addr); end
        n_assert++; if (dut.u_cam.valid !== 4'b0110) begin n_fail++; $display("FAIL erase_cam: got %b expected 0110", dut.u_cam.valid); end
        run_cmd(2'b01, 128'h66, P66, 1'b0);
        n_assert++; if (r_we_addr !== 2'd0 || r_we_data !== {128'h66, P66 ^ KEY}) begin n_fail++; $display("FAIL erase_reuse: got addr %0d data %h expected 0", r_we_addr, r_we_data); end
`else
        run_cmd(2'b10, 128'h11, '0, 1'b0);
        n_assert++; if (status !== 2'b11 || r_nwe !== 0 || dut.u_cam.valid !== 4'b0111) begin n_fail++; $display("FAIL illegal_op2: got status %b %0d writes cam %b expected 11 0 0111", status, r_nwe, dut.u_cam.valid); end
`endif
    endtask

    task automatic test_boot_bounds;
        do_reset(3'd0);
        n_assert++; if (r_boot !== 1 || dut.u_cam.valid !== 4'b0000) begin n_fail++; $display("FAIL boot_zero: got %0d cycles cam %b expected 1 0000", r_boot, dut.u_cam.valid); end
        run_cmd(2'b00, 128'h11, '0, 1'b0);
        n_assert++; if (status !== 2'b01) begin n_fail++; $display("FAIL boot_zero_fetch: got %b expected 01", status); end
        do_reset(3'd7);
        n_assert++; if (r_boot !== 8 || dut.u_cam.valid !== 4'b1111) begin n_fail++; $display("FAIL boot_clamp: got %0d cycles cam %b expected 8 1111", r_boot, dut.u_cam.valid); end
        run_cmd(2'b00, 128'h44, '0, 1'b0);
        n_assert++; if (password_out !== P44 || status !== 2'b00) begin n_fail++; $display("FAIL boot_clamp_fetch: got %h status %b expected %h 00", password_out, status, P44); end
    endtask

    initial begin
        test_reset();
        test_fetch_hit();
        test_fetch_miss();
        test_store();
        test_overwrite();
        test_busy_ignore();
        test_abort();
        test_illegal();
        test_boot_bounds();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
